// File: rtl/clz_seq_if.sv
// Request/response bundle between the execute stage and the CLZ/CLO sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; the requester watches busy and done itself.
interface clz_seq_if;
  logic        start;
  logic        op_clo;
  logic [31:0] value;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  // Execute stage side: issues operations and may abort them.
  modport master (
    output start,
    output op_clo,
    output value,
    output flush,
    input  busy,
    input  done,
    input  result
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  op_clo,
    input  value,
    input  flush,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/clz_seq.sv
// Multi-cycle count-leading-zeros/ones; scans CHUNK bits per cycle (CHUNK in 1,2,4,8).
// Latency: with CLZ_SEQ_EARLY_EXIT_EN, min(n/CHUNK+1, 32/CHUNK) cycles; without it, always 32/CHUNK.
// Backpressure: start is ignored while busy; flush drops the operation with no done.
module clz_seq #(
  parameter int CHUNK = 4
) (
  input  logic      clk,
  input  logic      rst,
  clz_seq_if.slave  io
);

  localparam int                STEPS     = 32 / CHUNK;
  localparam int                STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [5:0]        CHUNK_CNT = 6'(CHUNK);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       sh_q, sh_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;

`ifndef CLZ_SEQ_EARLY_EXIT_EN
  // Set once the first nonzero slice has been counted; later slices are ignored.
  logic              found_q, found_d;
  logic [5:0]        hit_cnt;
`endif

  logic [CHUNK-1:0]  slice;
  logic              slice_nz;
  logic [5:0]        slice_lz;

  // Leading zeros inside one slice; only meaningful when the slice is nonzero.
  function automatic logic [5:0] slice_lz_f(input logic [CHUNK-1:0] s);
    logic [5:0] n;
    logic       hit;
    n   = 6'd0;
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!hit) begin
        if (s[i]) hit = 1'b1;
        else      n   = n + 6'd1;
      end
    end
    return n;
  endfunction

  // Top slice of the shift register and its leading-zero count.
  always_comb begin
    slice    = sh_q[31 -: CHUNK];
    slice_nz = |slice;
    slice_lz = slice_lz_f(slice);
  end

  // Next-state and datapath for the IDLE/SCAN sequencer.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
    found_d  = found_q;
    if (found_q)       hit_cnt = cnt_q;
    else if (slice_nz) hit_cnt = cnt_q + slice_lz;
    else               hit_cnt = cnt_q + CHUNK_CNT;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          // Leading ones become leading zeros after inversion.
          sh_d    = io.op_clo ? ~io.value : io.value;
          cnt_d   = 6'd0;
          step_d  = '0;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
          found_d = 1'b0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (io.flush) begin
          // Abort wins over any terminating step: no done, result untouched.
          state_d = IDLE;
        end else begin
`ifdef CLZ_SEQ_EARLY_EXIT_EN
          if (slice_nz) begin
            result_d = {26'd0, cnt_q + slice_lz};
            done_d   = 1'b1;
            state_d  = IDLE;
          end else if (step_q == LAST_STEP) begin
            result_d = 32'd32;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d  = cnt_q + CHUNK_CNT;
            sh_d   = sh_q << CHUNK;
            step_d = step_q + STEP_ONE;
          end
`else
          // Fixed-length scan keeps stall timing independent of the operand.
          if (step_q == LAST_STEP) begin
            result_d = {26'd0, hit_cnt};
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d   = hit_cnt;
            found_d = found_q | slice_nz;
            sh_d    = sh_q << CHUNK;
            step_d  = step_q + STEP_ONE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= 32'd0;
      cnt_q    <= 6'd0;
      step_q   <= '0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
      found_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifndef CLZ_SEQ_EARLY_EXIT_EN
      found_q  <= found_d;
`endif
    end
  end

  assign io.busy   = (state_q == SCAN);
  assign io.done   = done_q;
  assign io.result = result_q;

endmodule

// File: tb/tb_clz_seq.sv
// Self-checking bench for clz_seq with CHUNK=4; latency expectations follow CLZ_SEQ_EARLY_EXIT_EN.
// A monitor pops expected result/latency pairs from a scoreboard on every done pulse.
// Scenario tasks add their own inline checks for reset, flush and start-while-busy.
module tb_clz_seq;

  localparam int CHUNK = 4;
  localparam int STEPS = 32 / CHUNK;

  logic clk;
  logic rst;
  clz_seq_if bus ();

  clz_seq #(.CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          exp_res_q[$];
  int          exp_lat_q[$];
  logic [31:0] last_exp = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_lat(input int n);
`ifdef CLZ_SEQ_EARLY_EXIT_EN
    return (n / CHUNK + 1 > STEPS) ? STEPS : n / CHUNK + 1;
`else
    return STEPS;
`endif
  endfunction

  // Scoreboard consumer: every done must match the oldest pending operation.
  task automatic monitor();
    int bcnt;
    int er;
    int el;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: result=%0d with no operation pending", bus.result);
        end else begin
          er = exp_res_q.pop_front();
          el = exp_lat_q.pop_front();
          if (bus.result !== 32'(er)) begin
            errors++;
            $display("FAIL result: got %0d expected %0d", bus.result, er);
          end
          checks++;
          if (bcnt != el) begin
            errors++;
            $display("FAIL latency: got %0d busy cycles expected %0d (result %0d)", bcnt, el, er);
          end
          checks++;
          if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_with_done: busy=%b while done=1", bus.busy);
          end
        end
        bcnt = 0;
      end else if (bus.busy === 1'b1) begin
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
  endtask

  // Drives a one-cycle start; scored operations push their expectation.
  task automatic issue(input bit clo, input logic [31:0] v, input int exp, input bit scored);
    bus.start  = 1'b1;
    bus.op_clo = clo;
    bus.value  = v;
    if (scored) begin
      exp_res_q.push_back(exp);
      exp_lat_q.push_back(exp_lat(exp));
      last_exp = 32'(exp);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (exp_res_q.size() == 0 && bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d operations still pending", exp_res_q.size());
      exp_res_q.delete();
      exp_lat_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    issue(1'b0, 32'h8000_0000, 0,  1'b1); wait_idle();
    issue(1'b0, 32'h0000_0001, 31, 1'b1); wait_idle();
    issue(1'b0, 32'h0000_0000, 32, 1'b1); wait_idle();
    issue(1'b1, 32'hFFFF_FFFF, 32, 1'b1); wait_idle();
    issue(1'b0, 32'h0000_0003, 30, 1'b1); wait_idle();
    issue(1'b1, 32'h7FFF_FFFF, 0,  1'b1); wait_idle();
  endtask

  task automatic test_back_to_back();
    bit seen;
    seen = 1'b0;
    issue(1'b1, 32'hFFFF_0000, 16, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_done: no done within 20 cycles, got 0 expected 1");
    end
    // Start in the done cycle must be taken with no bubble.
    issue(1'b0, 32'h0010_0000, 11, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", bus.busy); end
    wait_idle();
  endtask

  task automatic test_flush();
    bit busy_seen;
    busy_seen = 1'b0;
    bus.start  = 1'b1;
    bus.op_clo = 1'b0;
    bus.value  = 32'h0000_0001;
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_start_busy: got %b expected 1", bus.busy); end
    // Re-request while busy with an operand that would finish at once.
    bus.value = 32'h8000_0000;
    @(negedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_scan3_busy: got %b expected 1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.result !== last_exp) begin errors++; $display("FAIL flush_result: got %0d expected %0d", bus.result, last_exp); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin errors++; $display("FAIL start_not_queued: busy seen 1 expected 0"); end
  endtask

  task automatic test_async_reset();
    bit busy_seen;
    busy_seen = 1'b0;
    issue(1'b0, 32'h0000_0000, 0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL arst_result: got %0d expected 0", bus.result); end
    @(negedge clk);
    rst = 1'b0;
    last_exp = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 || bus.done === 1'b1) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin errors++; $display("FAIL arst_idle: activity seen after release, expected idle"); end
    issue(1'b0, 32'h0000_8000, 16, 1'b1);
    wait_idle();
  endtask

  task automatic test_random();
    int          sh;
    logic [31:0] v;
    bit          clo;
    for (int i = 0; i < 24; i++) begin
      sh  = $urandom_range(0, 32);
      v   = $urandom;
      v   = (sh == 32) ? 32'd0 : ((v | 32'h8000_0000) >> sh);
      clo = 1'($urandom_range(0, 1));
      if (clo) v = ~v;
      issue(clo, v, sh, 1'b1);
      wait_idle();
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_clo = 1'b0;
    bus.value  = 32'd0;
    bus.flush  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d pending expected 0", exp_res_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
